// File: rtl/relu_arbiter_pkg.sv
// Shared definitions for the ReLU arbiter: FSM state encoding, clamp counter
// width and saturation value, and the default activation word width.
package relu_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int             CLAMP_W      = 16;
    localparam logic [CLAMP_W-1:0] CLAMP_MAX = '1;
    localparam int             DEF_BITWIDTH = 32;

endpackage

// File: rtl/relu_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req       - per-requester request bits
//   last      - index of the most recent owner; search starts at last+1
//   grant_idx - first requesting index found walking upward (mod NREQ)
//   any       - high when at least one req bit is set
module rr_pick #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    // Walk from the farthest candidate back to the nearest so the nearest
    // requesting index (last+1, last+2, ...) is the one left in grant_idx.
    always_comb begin
        grant_idx = '0;
        any       = |req;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(last) + i) % NREQ]) begin
                grant_idx = IDW'((int'(last) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/relu_arbiter.sv
// Shares one ReLU lane between NREQ burst requesters. An owner is chosen
// round-robin while idle and keeps the lane until its req_last beat is taken.
// Each accepted word is clamped (negative -> 0) into a single output register.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   req_valid/req_data/req_last - per-requester input beats
//   req_ready                   - per-requester accept (at most one high)
//   out_valid/out_data/out_id/out_last, out_ready - output beat handshake
//   clamp_cnt                   - saturating count of negative input beats
//
// state | meaning
// IDLE  | no owner; pick next owner round-robin, no req_ready asserted
// BURST | owner locked; beats stream until the owner's req_last is accepted
module relu_arbiter
    import relu_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int NREQ     = 4,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BITWIDTH-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    output logic [BITWIDTH-1:0]      out_data,
    output logic [IDW-1:0]           out_id,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [CLAMP_W-1:0]       clamp_cnt
);

    state_t               state_q, state_d;
    logic [IDW-1:0]       owner_q, owner_d;
    logic [IDW-1:0]       last_owner_q;
    logic [IDW-1:0]       grant_idx;
    logic                 any_req;
    logic                 in_ready;
    logic                 in_xfer;
    logic                 in_last;
    logic [BITWIDTH-1:0]  in_data;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req       (req_valid),
        .last      (last_owner_q),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    // Input may be taken when the output register is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign in_data  = req_data[int'(owner_q)*BITWIDTH +: BITWIDTH];
    assign in_last  = req_last[owner_q];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        req_ready = '0;
        in_xfer   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BURST;
                    owner_d = grant_idx;
                end
            end
            BURST: begin
                req_ready[owner_q] = in_ready;
                in_xfer            = in_ready && req_valid[owner_q];
                if (in_xfer && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDW'(NREQ - 1);
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_id       <= '0;
            out_last     <= 1'b0;
            clamp_cnt    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (in_xfer && in_last) begin
                last_owner_q <= owner_q;
            end
            if (in_xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[BITWIDTH-1] ? '0 : in_data;
                out_id    <= owner_q;
                out_last  <= in_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_xfer && in_data[BITWIDTH-1] && clamp_cnt != CLAMP_MAX) begin
                clamp_cnt <= clamp_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_relu_arbiter.sv
// Directed bench for relu_arbiter: burst ordering, clamping, back-pressure,
// round-robin rotation, mid-burst reset and clamp counter saturation.
module tb_relu_arbiter;

    localparam int BW   = 32;
    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*BW-1:0]   req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic [BW-1:0]        out_data;
    logic [IDW-1:0]       out_id;
    logic                 out_last;
    logic                 out_ready;
    logic [15:0]          clamp_cnt;

    int checks = 0;
    int errors = 0;

    relu_arbiter #(.BITWIDTH(BW), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_ready (out_ready),
        .clamp_cnt (clamp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [BW-1:0] d, input logic l);
        req_valid[i]        = v;
        req_data[i*BW +: BW] = d;
        req_last[i]         = l;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b1;
        do_reset();
        settle();

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_out_id",    32'(out_id), 32'd0);
        check("rst_out_last",  32'(out_last), 32'd0);
        check("rst_clamp",     32'(clamp_cnt), 32'd0);
        check("rst_ready",     32'(req_ready), 32'd0);

        // Requester 2: {5, -7, 9}
        drive(2, 1'b1, 32'd5, 1'b0);
        settle();
        check("t1_idle_ready", 32'(req_ready), 32'd0);
        tick();
        check("t1_grant_ready", 32'(req_ready), 32'b0100);
        tick();
        drive(2, 1'b1, 32'hFFFF_FFF9, 1'b0);
        settle();
        check("t1_b0_valid", 32'(out_valid), 32'd1);
        check("t1_b0_data",  out_data, 32'd5);
        check("t1_b0_id",    32'(out_id), 32'd2);
        check("t1_b0_last",  32'(out_last), 32'd0);
        tick();
        drive(2, 1'b1, 32'd9, 1'b1);
        settle();
        check("t1_b1_data",  out_data, 32'd0);
        check("t1_b1_last",  32'(out_last), 32'd0);
        check("t1_b1_clamp", 32'(clamp_cnt), 32'd1);
        tick();
        drive(2, 1'b0, 32'd0, 1'b0);
        settle();
        check("t1_b2_data",  out_data, 32'd9);
        check("t1_b2_id",    32'(out_id), 32'd2);
        check("t1_b2_last",  32'(out_last), 32'd1);
        check("t1_b2_ready", 32'(req_ready), 32'd0);
        tick();
        check("t1_drain_valid", 32'(out_valid), 32'd0);
        check("t1_clamp_final", 32'(clamp_cnt), 32'd1);

        // Requesters 0 and 3 together after reset
        do_reset();
        drive(0, 1'b1, 32'd11, 1'b1);
        drive(3, 1'b1, 32'hFFFF_FFFF, 1'b1);
        tick();
        check("t2_grant0", 32'(req_ready), 32'b0001);
        tick();
        drive(0, 1'b0, 32'd0, 1'b0);
        settle();
        check("t2_out0_data", out_data, 32'd11);
        check("t2_out0_id",   32'(out_id), 32'd0);
        check("t2_idle_gap",  32'(req_ready), 32'd0);
        tick();
        check("t2_grant3", 32'(req_ready), 32'b1000);
        check("t2_gap_drain", 32'(out_valid), 32'd0);
        tick();
        drive(3, 1'b0, 32'd0, 1'b0);
        settle();
        check("t2_out3_id",   32'(out_id), 32'd3);
        check("t2_out3_data", out_data, 32'd0);
        check("t2_out3_clamp", 32'(clamp_cnt), 32'd1);
        tick();

        // Requester 1 burst with a 4-cycle output stall
        drive(1, 1'b1, 32'd100, 1'b0);
        tick();
        check("t3_grant1", 32'(req_ready), 32'b0010);
        tick();
        out_ready = 1'b0;
        drive(1, 1'b1, 32'd101, 1'b0);
        settle();
        check("t3_stall_ready0", 32'(req_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_stall_valid", 32'(out_valid), 32'd1);
            check("t3_stall_data",  out_data, 32'd100);
            check("t3_stall_id",    32'(out_id), 32'd1);
            check("t3_stall_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        settle();
        check("t3_release_ready", 32'(req_ready), 32'b0010);
        tick();
        drive(1, 1'b1, 32'd102, 1'b1);
        settle();
        check("t3_b1_data", out_data, 32'd101);
        check("t3_b1_valid", 32'(out_valid), 32'd1);
        tick();
        drive(1, 1'b0, 32'd0, 1'b0);
        settle();
        check("t3_b2_data", out_data, 32'd102);
        check("t3_b2_last", 32'(out_last), 32'd1);
        tick();
        check("t3_drain_valid", 32'(out_valid), 32'd0);

        // All four requesters continuously valid, single-beat bursts
        do_reset();
        for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 32'(10 + i), 1'b1);
        for (int k = 0; k < 2 * NREQ; k++) begin
            tick();
            check("t4_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
            check("t4_onehot_g", 32'($onehot0(req_ready)), 32'd1);
            tick();
            check("t4_out_id",   32'(out_id), 32'(k % NREQ));
            check("t4_out_data", out_data, 32'(10 + (k % NREQ)));
            check("t4_onehot_i", 32'($onehot0(req_ready)), 32'd1);
        end
        req_valid = '0;
        req_last  = '0;
        tick();

        // Reset pulsed mid-burst with a held output beat
        drive(2, 1'b1, 32'hFFFF_FFFD, 1'b0);
        tick();
        tick();
        out_ready = 1'b0;
        settle();
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_clamp", 32'(clamp_cnt), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        req_last  = '0;
        settle();
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_clamp", 32'(clamp_cnt), 32'd0);
        check("t5_data",  out_data, 32'd0);
        check("t5_ready", 32'(req_ready), 32'd0);
        drive(0, 1'b1, 32'd1, 1'b1);
        drive(2, 1'b1, 32'd2, 1'b1);
        tick();
        check("t5_prio0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        check("t5_out_id",   32'(out_id), 32'd0);
        check("t5_out_data", out_data, 32'd1);
        tick();

        // Clamp counter saturation
        do_reset();
        drive(1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tick();
        for (int n = 1; n <= 70000; n++) begin
            tick();
            if (n == 65534) check("t6_cnt_65534", 32'(clamp_cnt), 32'h0000_FFFE);
            if (n == 65535) check("t6_cnt_65535", 32'(clamp_cnt), 32'h0000_FFFF);
        end
        check("t6_cnt_sat",  32'(clamp_cnt), 32'h0000_FFFF);
        check("t6_out_data", out_data, 32'd0);
        drive(1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        check("t6_cnt_final", 32'(clamp_cnt), 32'h0000_FFFF);
        check("t6_last",      32'(out_last), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_arbiter.md
RELU_ARBITER -- requirements
Module: relu_arbiter

Interface
REQ-001 Parameter BITWIDTH, default 32: width of each activation word, two's complement.
REQ-002 Parameter NREQ, default 4: number of requesters sharing the ReLU lane (2..8).
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester beat valid.
REQ-006 req_data  input  NREQ*BITWIDTH  per-requester word; requester i occupies bits [i*BITWIDTH +: BITWIDTH].
REQ-007 req_last  input  NREQ  marks the final beat of a requester's burst.
REQ-008 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-009 out_valid  output  1  output beat valid.
REQ-010 out_data  output  BITWIDTH  ReLU result.
REQ-011 out_id  output  clog2(NREQ)  index of the requester that owns out_data.
REQ-012 out_last  output  1  registered copy of req_last for the beat.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 clamp_cnt  output  16  count of beats whose input was negative; saturates at 16'hFFFF.

Function
REQ-015 A beat transfers on an input port when req_valid[i] and req_ready[i] are both high, and on the output when out_valid and out_ready are both high.
REQ-016 The FSM has two states: IDLE (no owner) and BURST (owner locked).
REQ-017 In IDLE, with any req_valid high, the block selects the owner round-robin starting at (last_owner+1) mod NREQ, enters BURST on the next edge, and asserts no req_ready in that IDLE cycle.
REQ-018 In IDLE with no req_valid high, the block stays in IDLE.
REQ-019 In BURST, req_ready[owner] = out_valid==0 || out_ready; all other req_ready bits are 0.
REQ-020 When a beat with req_last=1 is accepted in BURST, the block updates last_owner to the owner and returns to IDLE on the next edge.
REQ-021 Ownership never changes mid-burst, regardless of other requesters' req_valid.
REQ-022 The output register loads on an input transfer: out_data = 0 if the input MSB is 1, else the input word unchanged; out_id = owner; out_last = req_last.
REQ-023 Latency from input transfer to out_valid is exactly 1 cycle; sustained throughput is 1 beat/cycle within a burst.
REQ-024 If out_valid=1 and out_ready=0, out_data, out_id, out_last and out_valid hold stable and req_ready[owner] is 0.
REQ-025 If an output transfer and an input transfer occur in the same cycle, the register reloads and out_valid stays 1; an output transfer alone clears out_valid.
REQ-026 clamp_cnt increments by 1 on each input transfer with MSB=1 and holds at 16'hFFFF.
REQ-027 Inter-burst overhead is one IDLE cycle; with all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.

Reset
REQ-028 While rst=1, at the next edge: state=IDLE; last_owner=NREQ-1, so requester 0 has first priority; out_valid=0; out_data=0; out_id=0; out_last=0; clamp_cnt=0; req_ready=0.
REQ-029 Reset asserted mid-burst discards the held output beat and the burst lock, with no partial completion.

Structure
REQ-030 A shared package relu_pkg holds the state enum (IDLE, BURST), the clamp counter width constant (16) and the default BITWIDTH.
REQ-031 The round-robin selection is a combinational sub-module rr_pick with inputs req[NREQ] and last[clog2 NREQ] and outputs grant_idx and any.
REQ-032 The ReLU clamp is inline combinational logic feeding the single output register; the block has no other data storage.

Verification
REQ-033 After reset, requester 2 sends 3 beats {5, -7, 9} with last on the third -> out sequence {5, 0, 9}, out_id=2 each, out_last on the third beat only, clamp_cnt=1.
REQ-034 Requesters 0 and 3 request simultaneously after reset -> requester 0 bursts first; requester 3 is granted after exactly one IDLE cycle.
REQ-035 out_ready is held low for 4 cycles mid-burst -> output beat stable, req_ready[owner]=0 throughout; no beat is lost or duplicated after release.
REQ-036 All 4 requesters send continuous single-beat bursts -> grant order 0,1,2,3,0,...; no req_ready bits ever high together.
REQ-037 rst is pulsed during a burst with out_valid=1 -> next cycle out_valid=0, clamp_cnt=0, state IDLE, requester 0 has priority.
REQ-038 70000 negative beats are sent -> clamp_cnt saturates at 65535 and does not wrap.
